// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave datapath blocks.
//   state_t   : frame sequencer states
//   DEF_WIDTH : default number of bits per frame
//   LSB_FIRST : bit order on the serial line (1 = bit 0 goes out first)
package spi_pkg;

   localparam int DEF_WIDTH = 12;
   localparam bit LSB_FIRST = 1'b1;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      WAIT_CS
   } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Brings an asynchronous pin into the clk domain and flags its edges.
//   clk, rst : system clock, synchronous active-high reset
//   din      : asynchronous pin
//   level    : synchronized level, aligned with the strobes
//   rise     : one-clk strobe, SYNC_STAGES+1 clks after a 0->1 pin change
//   fall     : one-clk strobe, SYNC_STAGES+1 clks after a 1->0 pin change
// SYNC_STAGES must be at least 2. RESET_VAL presets the whole chain so
// that no edge is reported when reset releases with the pin at that level.
module spi_sync_edge #(
   parameter int SYNC_STAGES = 2,
   parameter bit RESET_VAL   = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] chain;
   logic                   last;

   always_ff @(posedge clk) begin
      if (rst) begin
         chain <= {SYNC_STAGES{RESET_VAL}};
         last  <= RESET_VAL;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         chain <= {chain[SYNC_STAGES-2:0], din};
         last  <= chain[SYNC_STAGES-1];
         rise  <= chain[SYNC_STAGES-1] & ~last;
         fall  <= ~chain[SYNC_STAGES-1] & last;
      end
   end

   assign level = last;

endmodule

// File: rtl/spi_slave_tx.sv
// SPI slave transmitter: drives WIDTH-bit words on miso, framed by an
// active-low cs, with a single-entry holding register for the next word.
//   clk, rst : system clock, synchronous active-high reset
//   sclk, cs : serial clock and chip select from the master (asynchronous)
//   load/din : host write of the next word, accepted when ready=1
//   ready    : holding register empty
//   miso     : serial data to the master
//   busy     : frame in progress (SHIFT or WAIT_CS)
//   done     : one-clk pulse after the WIDTH-th sclk rise
//   underrun : one-clk pulse, frame started with nothing queued
//   abort    : one-clk pulse, cs released before WIDTH bits were sampled
module spi_slave_tx
   import spi_pkg::*;
#(
   parameter int WIDTH       = DEF_WIDTH,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sclk,
   input  logic             cs,
   input  logic             load,
   input  logic [WIDTH-1:0] din,
   output logic             ready,
   output logic             miso,
   output logic             busy,
   output logic             done,
   output logic             underrun,
   output logic             abort
);

   localparam int CNT_W    = $clog2(WIDTH + 1);
   localparam int SETTLE_W = $clog2(SYNC_STAGES + 3);
   localparam int FIRST    = LSB_FIRST ? 0 : WIDTH - 1;
   localparam logic [CNT_W-1:0]    LAST_BIT    = CNT_W'(WIDTH - 1);
   localparam logic [SETTLE_W-1:0] SETTLE_INIT = SETTLE_W'(SYNC_STAGES + 2);

   logic sclk_lvl, sclk_rise, sclk_fall;
   logic cs_lvl, cs_rise, cs_fall;

   state_t           state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [WIDTH-1:0] shreg, shreg_n, shifted;
   logic             miso_n, done_n, underrun_n, abort_n;
   logic             frame_start;

   logic [WIDTH-1:0]    hold;
   logic                hold_valid;
   logic [SETTLE_W-1:0] settle;
   logic                cs_armed;

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
      .clk   (clk),
      .rst   (rst),
      .din   (sclk),
      .level (sclk_lvl),
      .rise  (sclk_rise),
      .fall  (sclk_fall)
   );

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
      .clk   (clk),
      .rst   (rst),
      .din   (cs),
      .level (cs_lvl),
      .rise  (cs_rise),
      .fall  (cs_fall)
   );

   // After reset the cs chain still holds its preset; if the pin is already
   // low that preset flushes out as a fall. Frames are only accepted once cs
   // has been seen genuinely high after the chain has settled.
   always_ff @(posedge clk) begin
      if (rst) begin
         settle   <= SETTLE_INIT;
         cs_armed <= 1'b0;
      end else begin
         if (settle != '0) begin
            settle <= settle - SETTLE_W'(1);
         end else if (cs_lvl) begin
            cs_armed <= 1'b1;
         end
      end
   end

   // Holding register: a load in the frame-start cycle refills it for the next frame
   always_ff @(posedge clk) begin
      if (rst) begin
         hold       <= '0;
         hold_valid <= 1'b0;
      end else begin
         if (frame_start) begin
            hold_valid <= 1'b0;
         end
         if (load && !hold_valid) begin
            hold       <= din;
            hold_valid <= 1'b1;
         end
      end
   end

   assign shifted = LSB_FIRST ? (shreg >> 1) : (shreg << 1);

   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      shreg_n     = shreg;
      miso_n      = miso;
      done_n      = 1'b0;
      underrun_n  = 1'b0;
      abort_n     = 1'b0;
      frame_start = 1'b0;
      case (state)
         IDLE: begin
            miso_n = 1'b0;
            if (cs_fall && cs_armed) begin
               frame_start = 1'b1;
               state_n     = SHIFT;
               cnt_n       = '0;
               if (hold_valid) begin
                  shreg_n = hold;
                  miso_n  = hold[FIRST];
               end else begin
                  shreg_n    = '0;
                  underrun_n = 1'b1;
               end
            end
         end
         SHIFT: begin
            // The final sclk rise wins over a coincident cs release
            if (sclk_rise && sclk_lvl && cnt == LAST_BIT) begin
               done_n  = 1'b1;
               miso_n  = 1'b0;
               cnt_n   = cnt + CNT_W'(1);
               state_n = cs_rise ? IDLE : WAIT_CS;
            end else if (cs_rise) begin
               abort_n = 1'b1;
               miso_n  = 1'b0;
               state_n = IDLE;
            end else if (sclk_rise && sclk_lvl) begin
               cnt_n = cnt + CNT_W'(1);
            end else if (sclk_fall && !sclk_lvl && cnt != '0) begin
               shreg_n = shifted;
               miso_n  = shifted[FIRST];
            end
         end
         WAIT_CS: begin
            miso_n = 1'b0;
            if (cs_rise) begin
               state_n = IDLE;
            end
         end
         default: begin
            state_n = IDLE;
            miso_n  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         shreg    <= '0;
         miso     <= 1'b0;
         done     <= 1'b0;
         underrun <= 1'b0;
         abort    <= 1'b0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         shreg    <= shreg_n;
         miso     <= miso_n;
         done     <= done_n;
         underrun <= underrun_n;
         abort    <= abort_n;
      end
   end

   assign ready = ~hold_valid;
   assign busy  = (state != IDLE);

endmodule

// File: tb/tb_spi_slave_tx.sv
module tb_spi_slave_tx;

   localparam int W  = 12;
   localparam int SS = 2;
   localparam int H  = 11;

   logic         clk = 1'b0;
   logic         rst, sclk, cs, load;
   logic [W-1:0] din;
   logic         ready, miso, busy, done, underrun, abort;

   spi_slave_tx #(.WIDTH(W), .SYNC_STAGES(SS)) dut (
      .clk      (clk),
      .rst      (rst),
      .sclk     (sclk),
      .cs       (cs),
      .load     (load),
      .din      (din),
      .ready    (ready),
      .miso     (miso),
      .busy     (busy),
      .done     (done),
      .underrun (underrun),
      .abort    (abort)
   );

   always #5 clk = ~clk;

   int vecs = 0;
   int miss = 0;
   int n_done = 0, n_und = 0, n_abort = 0;

   always @(negedge clk) begin
      if (done)     n_done  <= n_done + 1;
      if (underrun) n_und   <= n_und + 1;
      if (abort)    n_abort <= n_abort + 1;
   end

   // Reference model of the holding register: one slot, filled only when empty
   bit           m_valid;
   logic [W-1:0] m_hold;

   typedef struct {
      bit           ld;
      logic [W-1:0] w;
      int           rises;
      bit           coin;
      bit           mid;
      logic [W-1:0] mw;
      logic [W-1:0] exp_bits;
      bit           exp_done;
      bit           exp_und;
      bit           exp_abort;
      bit           exp_ready;
   } vec_t;

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         miss++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic host_load(input logic [W-1:0] w);
      load = 1'b1;
      din  = w;
      tick();
      load = 1'b0;
      if (!m_valid) begin
         m_valid = 1'b1;
         m_hold  = w;
      end
   endtask

   function automatic logic [W-1:0] mask_of(input int rises);
      logic [W-1:0] one;
      one = W'(1);
      return (rises >= W) ? '1 : ((one << rises) - one);
   endfunction

   // Master side: sample miso just before each sclk rise, then release cs
   task automatic shift_bits(input int rises, input bit coin, input bit mid,
                             input logic [W-1:0] mw, output logic [W-1:0] got);
      got = '0;
      for (int i = 0; i < rises; i++) begin
         got[i] = miso;
         if (coin && i == rises - 1) cs = 1'b1;
         sclk = 1'b1;
         tick(H);
         sclk = 1'b0;
         tick(H);
         if (mid && i == 3) begin
            host_load(mw);
            check("ready_after_midload", ready, !m_valid);
         end
      end
      cs = 1'b1;
      tick(SS + 6);
   endtask

   task automatic run_frame(input bit ld, input logic [W-1:0] w, input int rises,
                            input bit coin, input bit mid, input logic [W-1:0] mw,
                            output logic [W-1:0] got, output logic [W-1:0] mexp,
                            output bit mund);
      if (ld) host_load(w);
      mexp    = m_valid ? m_hold : '0;
      mund    = !m_valid;
      m_valid = 1'b0;
      cs = 1'b0;
      tick(SS + 4);
      check("busy_in_frame", busy, 1);
      check("ready_in_frame", ready, !m_valid);
      shift_bits(rises, coin, mid, mw, got);
   endtask

   vec_t         vt[7];
   logic [W-1:0] got, mexp, mk;
   bit           mund;
   int           d0, u0, a0;

   initial begin
      #5ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; sclk = 1'b0; cs = 1'b1; load = 1'b0; din = '0;
      m_valid = 1'b0; m_hold = '0;
      tick(3);
      check("rst_miso", miso, 0);
      check("rst_ready", ready, 1);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_underrun", underrun, 0);
      check("rst_abort", abort, 0);
      rst = 1'b0;
      tick(SS + 6);

      //          ld  w        rises coin mid mw       exp_bits done und ab  rdy
      vt[0] = '{1'b1, 12'hA5C, 12, 1'b0, 1'b0, 12'h000, 12'hA5C, 1'b1, 1'b0, 1'b0, 1'b1};
      vt[1] = '{1'b1, 12'h001, 12, 1'b0, 1'b1, 12'hFFF, 12'h001, 1'b1, 1'b0, 1'b0, 1'b0};
      vt[2] = '{1'b0, 12'h000, 12, 1'b0, 1'b0, 12'h000, 12'hFFF, 1'b1, 1'b0, 1'b0, 1'b1};
      vt[3] = '{1'b0, 12'h000, 12, 1'b0, 1'b0, 12'h000, 12'h000, 1'b1, 1'b1, 1'b0, 1'b1};
      vt[4] = '{1'b1, 12'h5A5,  5, 1'b0, 1'b0, 12'h000, 12'h005, 1'b0, 1'b0, 1'b1, 1'b1};
      vt[5] = '{1'b1, 12'h123, 12, 1'b0, 1'b0, 12'h000, 12'h123, 1'b1, 1'b0, 1'b0, 1'b1};
      vt[6] = '{1'b1, 12'h7E1, 12, 1'b1, 1'b0, 12'h000, 12'h7E1, 1'b1, 1'b0, 1'b0, 1'b1};

      for (int k = 0; k < 7; k++) begin
         d0 = n_done; u0 = n_und; a0 = n_abort;
         run_frame(vt[k].ld, vt[k].w, vt[k].rises, vt[k].coin, vt[k].mid, vt[k].mw,
                   got, mexp, mund);
         mk = mask_of(vt[k].rises);
         check($sformatf("vec%0d_bits", k), got & mk, vt[k].exp_bits);
         check($sformatf("vec%0d_done", k), n_done - d0, vt[k].exp_done);
         check($sformatf("vec%0d_underrun", k), n_und - u0, vt[k].exp_und);
         check($sformatf("vec%0d_abort", k), n_abort - a0, vt[k].exp_abort);
         check($sformatf("vec%0d_miso_idle", k), miso, 0);
         check($sformatf("vec%0d_busy_idle", k), busy, 0);
         check($sformatf("vec%0d_ready", k), ready, vt[k].exp_ready);
      end

      // Load coinciding with the internal cs fall while the register is empty
      d0 = n_done; u0 = n_und;
      cs = 1'b0;
      tick(SS + 1);
      load = 1'b1; din = 12'h3C7;
      tick();
      load = 1'b0;
      m_valid = 1'b1; m_hold = 12'h3C7;
      tick(2);
      shift_bits(W, 1'b0, 1'b0, '0, got);
      check("coload_bits", got, 12'h000);
      check("coload_underrun", n_und - u0, 1);
      check("coload_done", n_done - d0, 1);
      check("coload_ready", ready, 0);
      u0 = n_und;
      run_frame(1'b0, '0, W, 1'b0, 1'b0, '0, got, mexp, mund);
      check("coload_next_bits", got, 12'h3C7);
      check("coload_next_underrun", n_und - u0, 0);

      // Reset during bit 6, with a second word queued that must be discarded
      host_load(12'h6B9);
      m_valid = 1'b0;
      cs = 1'b0;
      tick(SS + 4);
      for (int i = 0; i < 6; i++) begin
         sclk = 1'b1; tick(H);
         sclk = 1'b0; tick(H);
         if (i == 2) host_load(12'h111);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      m_valid = 1'b0;
      check("midrst_miso", miso, 0);
      check("midrst_ready", ready, 1);
      check("midrst_busy", busy, 0);
      u0 = n_und;
      for (int i = 0; i < 3; i++) begin
         sclk = 1'b1; tick(H);
         sclk = 1'b0; tick(H);
      end
      check("midrst_no_frame_busy", busy, 0);
      check("midrst_no_frame_underrun", n_und - u0, 0);
      cs = 1'b1;
      tick(SS + 6);
      run_frame(1'b0, '0, W, 1'b0, 1'b0, '0, got, mexp, mund);
      check("postrst_bits", got, 12'h000);
      check("postrst_underrun", n_und - u0, 1);

      // Randomized frames against the holding-register model
      for (int k = 0; k < 24; k++) begin
         int  kind, rises;
         bit  ld, coin, mid;
         logic [W-1:0] w, mw;
         kind  = $urandom_range(0, 9);
         ld    = ($urandom_range(0, 9) < 7);
         w     = W'($urandom);
         mw    = W'($urandom);
         coin  = (kind == 7);
         rises = (kind >= 8) ? $urandom_range(1, W - 1) : W;
         mid   = (rises >= 4) && ($urandom_range(0, 9) < 3);
         d0 = n_done; u0 = n_und; a0 = n_abort;
         run_frame(ld, w, rises, coin, mid, mw, got, mexp, mund);
         mk = mask_of(rises);
         check($sformatf("rnd%0d_bits", k), got & mk, mexp & mk);
         check($sformatf("rnd%0d_done", k), n_done - d0, (rises == W) ? 1 : 0);
         check($sformatf("rnd%0d_abort", k), n_abort - a0, (rises < W) ? 1 : 0);
         check($sformatf("rnd%0d_underrun", k), n_und - u0, mund);
         check($sformatf("rnd%0d_ready", k), ready, !m_valid);
         check($sformatf("rnd%0d_busy", k), busy, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
      $finish;
   end

endmodule
